// File: rtl/chipselect_sequencer_if.sv
// rtl/chipselect_sequencer_if.sv - request/strobe bundle between a bus master and chipselect_sequencer
interface chipselect_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int SEL_W  = 2
);
    localparam int NUM_CS = 2 ** SEL_W;

    logic                    req;      // access request, taken only while ready
    logic                    we;       // 1 = write, 0 = read
    logic [ADDR_W-1:0]       addr;     // top SEL_W bits pick the bank
    logic [NUM_CS-1:0]       bank_en;  // per-bank enable mask
    logic                    ready;    // controller idle
    logic [NUM_CS-1:0]       cs;       // one-hot chip selects
    logic [ADDR_W-SEL_W-1:0] offset;   // latched low address bits
    logic                    rd_en;    // read strobe
    logic                    wr_en;    // write strobe
    logic                    done;     // access completed pulse
    logic                    err;      // request rejected pulse

    modport master (
        output req, we, addr, bank_en,
        input  ready, cs, offset, rd_en, wr_en, done, err
    );

    modport slave (
        input  req, we, addr, bank_en,
        output ready, cs, offset, rd_en, wr_en, done, err
    );
endinterface

// File: rtl/chipselect_sequencer.sv
// rtl/chipselect_sequencer.sv - bank-decoding chip-select controller with timed setup/access/hold strobes
module chipselect_sequencer #(
    parameter int ADDR_W        = 8,
    parameter int SEL_W         = 2,
    parameter int SETUP_CYCLES  = 1,
    parameter int ACCESS_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chipselect_sequencer_if.slave bus
);
    localparam int NUM_CS = 2 ** SEL_W;
    localparam int OFF_W  = ADDR_W - SEL_W;

    // Phase counters are loaded with count-1 and the phase ends when they hit 0.
    localparam logic [7:0] SETUP_LD  = (SETUP_CYCLES  > 0) ? 8'(SETUP_CYCLES - 1)  : 8'd0;
    localparam logic [7:0] ACCESS_LD = (ACCESS_CYCLES > 0) ? 8'(ACCESS_CYCLES - 1) : 8'd0;
    localparam logic [7:0] HOLD_LD   = (HOLD_CYCLES   > 0) ? 8'(HOLD_CYCLES - 1)   : 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [SEL_W-1:0]   bank_q, bank_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic               we_q, we_d;
    logic [NUM_CS-1:0]  cs_q, cs_d;
    logic               rd_en_q, rd_en_d;
    logic               wr_en_q, wr_en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [SEL_W-1:0]   req_bank;

    assign req_bank = bus.addr[ADDR_W-1 -: SEL_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            bank_q   <= '0;
            offset_q <= '0;
            we_q     <= 1'b0;
            cs_q     <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            offset_q <= offset_d;
            we_q     <= we_d;
            cs_q     <= cs_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bank_d   = bank_q;
        offset_d = offset_q;
        we_d     = we_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cs_d     = '0;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    bank_d = req_bank;
                    we_d   = bus.we;
                    if (bus.bank_en[req_bank]) begin
                        offset_d = bus.addr[OFF_W-1:0];
                        if (SETUP_CYCLES == 0) begin
                            state_d = ST_ACTIVE;
                            cnt_d   = ACCESS_LD;
                        end else begin
                            state_d = ST_SETUP;
                            cnt_d   = SETUP_LD;
                        end
                    end else begin
                        // Rejected requests never expose their offset.
                        state_d  = ST_ERR;
                        offset_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = ACCESS_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == 8'd0) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d  = ST_IDLE;
                        offset_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d  = ST_IDLE;
                    offset_d = '0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered: derive them from the state being entered.
        if (state_d == ST_SETUP || state_d == ST_ACTIVE || state_d == ST_HOLD) begin
            cs_d[bank_d] = 1'b1;
        end
        if (state_d == ST_ACTIVE) begin
            rd_en_d = ~we_d;
            wr_en_d = we_d;
        end
    end

    assign bus.ready  = (state_q == ST_IDLE);
    assign bus.cs     = cs_q;
    assign bus.offset = offset_q;
    assign bus.rd_en  = rd_en_q;
    assign bus.wr_en  = wr_en_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_chipselect_sequencer.sv
// tb/tb_chipselect_sequencer.sv - directed self-checking bench for chipselect_sequencer
module tb_chipselect_sequencer;
    logic clk;
    logic rst_n;

    int vectors;
    int errors;

    chipselect_sequencer_if #(.ADDR_W(8),  .SEL_W(2)) if_def ();
    chipselect_sequencer_if #(.ADDR_W(8),  .SEL_W(2)) if_fast ();
    chipselect_sequencer_if #(.ADDR_W(10), .SEL_W(3)) if_wide ();

    chipselect_sequencer #(
        .ADDR_W(8), .SEL_W(2), .SETUP_CYCLES(1), .ACCESS_CYCLES(2), .HOLD_CYCLES(1)
    ) u_def (
        .clk(clk), .rst_n(rst_n), .bus(if_def.slave)
    );

    chipselect_sequencer #(
        .ADDR_W(8), .SEL_W(2), .SETUP_CYCLES(0), .ACCESS_CYCLES(3), .HOLD_CYCLES(0)
    ) u_fast (
        .clk(clk), .rst_n(rst_n), .bus(if_fast.slave)
    );

    chipselect_sequencer #(
        .ADDR_W(10), .SEL_W(3), .SETUP_CYCLES(1), .ACCESS_CYCLES(2), .HOLD_CYCLES(1)
    ) u_wide (
        .clk(clk), .rst_n(rst_n), .bus(if_wide.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        if_def.req  = 1'b0; if_def.we  = 1'b0; if_def.addr  = '0; if_def.bank_en  = '1;
        if_fast.req = 1'b0; if_fast.we = 1'b0; if_fast.addr = '0; if_fast.bank_en = '1;
        if_wide.req = 1'b0; if_wide.we = 1'b0; if_wide.addr = '0; if_wide.bank_en = '1;

        // Reset values, with req asserted during reset (must be ignored).
        if_def.req = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(if_def.ready),  32'd1);
        check("rst_cs",    32'(if_def.cs),     32'd0);
        check("rst_off",   32'(if_def.offset), 32'd0);
        check("rst_rd",    32'(if_def.rd_en),  32'd0);
        check("rst_wr",    32'(if_def.wr_en),  32'd0);
        check("rst_done",  32'(if_def.done),   32'd0);
        check("rst_err",   32'(if_def.err),    32'd0);
        if_def.req = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_idle_cs", 32'(if_def.cs), 32'd0);

        // Default timing read of 0x85.
        if_def.req = 1'b1; if_def.we = 1'b0; if_def.addr = 8'h85; if_def.bank_en = 4'b1111;
        tick();
        if_def.req = 1'b0;
        check("rd_t1_cs",    32'(if_def.cs),     32'h4);
        check("rd_t1_off",   32'(if_def.offset), 32'h05);
        check("rd_t1_rd",    32'(if_def.rd_en),  32'd0);
        check("rd_t1_ready", 32'(if_def.ready),  32'd0);
        tick();
        check("rd_t2_rd",    32'(if_def.rd_en),  32'd1);
        check("rd_t2_wr",    32'(if_def.wr_en),  32'd0);
        tick();
        check("rd_t3_rd",    32'(if_def.rd_en),  32'd1);
        check("rd_t3_cs",    32'(if_def.cs),     32'h4);
        tick();
        check("rd_t4_rd",    32'(if_def.rd_en),  32'd0);
        check("rd_t4_cs",    32'(if_def.cs),     32'h4);
        check("rd_t4_done",  32'(if_def.done),   32'd0);
        tick();
        check("rd_t5_cs",    32'(if_def.cs),     32'd0);
        check("rd_t5_done",  32'(if_def.done),   32'd1);
        check("rd_t5_ready", 32'(if_def.ready),  32'd1);
        tick();
        check("rd_t6_done",  32'(if_def.done),   32'd0);

        // Write of 0xC3 with no setup/hold phases and three access cycles.
        if_fast.req = 1'b1; if_fast.we = 1'b1; if_fast.addr = 8'hC3;
        tick();
        if_fast.req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("wr_t%0d_cs", i), 32'(if_fast.cs),    32'h8);
            check($sformatf("wr_t%0d_wr", i), 32'(if_fast.wr_en), 32'd1);
            check($sformatf("wr_t%0d_rd", i), 32'(if_fast.rd_en), 32'd0);
            tick();
        end
        check("wr_t4_done",  32'(if_fast.done),  32'd1);
        check("wr_t4_cs",    32'(if_fast.cs),    32'd0);
        check("wr_t4_wr",    32'(if_fast.wr_en), 32'd0);

        // Disabled bank 1 is rejected.
        if_def.req = 1'b1; if_def.we = 1'b0; if_def.addr = 8'h40; if_def.bank_en = 4'b1101;
        tick();
        if_def.req = 1'b0;
        check("err_t1_err",   32'(if_def.err),   32'd1);
        check("err_t1_cs",    32'(if_def.cs),    32'd0);
        check("err_t1_rd",    32'(if_def.rd_en), 32'd0);
        check("err_t1_ready", 32'(if_def.ready), 32'd0);
        tick();
        check("err_t2_ready", 32'(if_def.ready), 32'd1);
        check("err_t2_err",   32'(if_def.err),   32'd0);
        check("err_t2_done",  32'(if_def.done),  32'd0);
        if_def.bank_en = 4'b1111;

        // Back-to-back: req held high, addr 0x00 then 0xFF.
        if_def.req = 1'b1; if_def.addr = 8'h00;
        tick();
        check("b2b_first_cs", 32'(if_def.cs), 32'h1);
        if_def.addr = 8'hFF;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("b2b_t%0d_cs", i), 32'(if_def.cs), 32'h1);
        end
        tick();
        check("b2b_gap_cs",   32'(if_def.cs),   32'd0);
        check("b2b_gap_done", 32'(if_def.done), 32'd1);
        tick();
        if_def.req = 1'b0;
        check("b2b_second_cs",  32'(if_def.cs),     32'h8);
        check("b2b_second_off", 32'(if_def.offset), 32'h3F);
        tick(); tick(); tick();
        check("b2b_second_hold_cs", 32'(if_def.cs), 32'h8);
        tick();
        check("b2b_second_done", 32'(if_def.done), 32'd1);

        // Reset during ACTIVE of a read.
        tick();
        if_def.req = 1'b1; if_def.we = 1'b0; if_def.addr = 8'h85;
        tick();
        if_def.req = 1'b0;
        tick();
        check("rstmid_active_rd", 32'(if_def.rd_en), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rstmid_cs",    32'(if_def.cs),    32'd0);
        check("rstmid_rd",    32'(if_def.rd_en), 32'd0);
        check("rstmid_ready", 32'(if_def.ready), 32'd1);
        check("rstmid_done",  32'(if_def.done),  32'd0);
        rst_n = 1'b1;
        tick();
        check("rstmid_rel_done", 32'(if_def.done), 32'd0);
        if_def.req = 1'b1; if_def.we = 1'b1; if_def.addr = 8'h85;
        tick();
        if_def.req = 1'b0;
        check("rstmid_new_cs", 32'(if_def.cs), 32'h4);
        tick();
        check("rstmid_new_wr", 32'(if_def.wr_en), 32'd1);
        tick(); tick(); tick();
        check("rstmid_new_done", 32'(if_def.done), 32'd1);

        // Wide configuration: addr 0x3A5 -> bank 7, offset 0x25.
        if_wide.req = 1'b1; if_wide.we = 1'b0; if_wide.addr = 10'h3A5;
        tick();
        if_wide.req = 1'b0;
        check("wide_cs",  32'(if_wide.cs),     32'h80);
        check("wide_off", 32'(if_wide.offset), 32'h25);
        tick(); tick(); tick(); tick();
        check("wide_done", 32'(if_wide.done), 32'd1);

        // Sweep all eight banks.
        for (int b = 0; b < 8; b++) begin
            if_wide.req  = 1'b1;
            if_wide.addr = 10'(b << 7) | 10'h011;
            tick();
            if_wide.req = 1'b0;
            check($sformatf("sweep_b%0d_cs", b), 32'(if_wide.cs), 32'(1) << b);
            for (int k = 0; k < 3; k++) begin
                tick();
                check($sformatf("sweep_b%0d_onehot%0d", b, k), 32'($countones(if_wide.cs)), 32'd1);
            end
            tick();
            check($sformatf("sweep_b%0d_done", b), 32'(if_wide.done), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
